// File: rtl/butterfly_sequencer_pkg.sv
// Shared constants, state encoding, AGU payload and butterfly index helpers for butterfly_sequencer.
// Optional BFSEQ_ROWBASE_EN widens data addresses to {row,local}.
package butterfly_sequencer_pkg;

    localparam int unsigned N_POINTS = 16;
    localparam int unsigned LOG2N    = 4;
    localparam int unsigned DATA_AW  = LOG2N + 1;
    localparam int unsigned TW_AW    = LOG2N;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned BF_W     = LOG2N - 1;
    localparam int unsigned STAGE_W  = (LOG2N > 1) ? $clog2(LOG2N) : 1;
`ifdef BFSEQ_ROWBASE_EN
    localparam int unsigned ROW_AW   = LOG2N;
    localparam int unsigned ADDR_W   = DATA_AW + ROW_AW;
`else
    localparam int unsigned ADDR_W   = DATA_AW;
`endif

    localparam logic [BF_W-1:0]    BF_LAST    = BF_W'(N_POINTS / 2 - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

    // Per-butterfly slot schedule within the 8-cycle window
    localparam logic [CNT_W-1:0] SLOT_B_RE    = CNT_W'(0);
    localparam logic [CNT_W-1:0] SLOT_W_RE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SLOT_B_IM    = CNT_W'(2);
    localparam logic [CNT_W-1:0] SLOT_W_IM    = CNT_W'(3);
    localparam logic [CNT_W-1:0] SLOT_A_RE    = CNT_W'(4);
    localparam logic [CNT_W-1:0] SLOT_A_IM    = CNT_W'(5);
    localparam logic [CNT_W-1:0] SLOT_WR_A_RE = CNT_W'(6);
    localparam logic [CNT_W-1:0] SLOT_WR_A_IM = CNT_W'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_CLR
    } state_t;

    typedef struct packed {
        logic [DATA_AW-1:0] rd_addr;
        logic [DATA_AW-1:0] wr_addr;
        logic               wr_en;
        logic [TW_AW-1:0]   tw_addr;
        logic               tw_sel;
    } agu_out_t;

    function automatic logic [LOG2N-1:0] bfly_a(input logic [STAGE_W-1:0] stage,
                                                input logic [BF_W-1:0] bf);
        int unsigned s;
        int unsigned v;
        int unsigned lo;
        s  = 32'(stage);
        v  = 32'(bf);
        lo = v & ((32'd1 << s) - 32'd1);
        return LOG2N'(((v >> s) << (s + 32'd1)) + lo);
    endfunction

    function automatic logic [LOG2N-1:0] bfly_b(input logic [STAGE_W-1:0] stage,
                                                input logic [BF_W-1:0] bf);
        return bfly_a(stage, bf) + LOG2N'(32'd1 << 32'(stage));
    endfunction

    function automatic logic [BF_W-1:0] bfly_k(input logic [STAGE_W-1:0] stage,
                                               input logic [BF_W-1:0] bf);
        int unsigned s;
        int unsigned lo;
        s  = 32'(stage);
        lo = 32'(bf) & ((32'd1 << s) - 32'd1);
        return BF_W'(lo << (LOG2N - 32'd1 - s));
    endfunction

endpackage

// File: rtl/butterfly_sequencer_agu.sv
// Combinational address generator: maps (state, stage, bf, cnt, previous B) to RAM/ROM addresses and strobes.
module butterfly_sequencer_agu
    import butterfly_sequencer_pkg::*;
(
    input  state_t             state,
    input  logic [STAGE_W-1:0] stage,
    input  logic [BF_W-1:0]    bf,
    input  logic [CNT_W-1:0]   cnt,
    input  logic [LOG2N-1:0]   prev_b,
    output agu_out_t           agu
);

    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic [BF_W-1:0]  k;
    logic             first;

    assign a     = bfly_a(stage, bf);
    assign b     = bfly_b(stage, bf);
    assign k     = bfly_k(stage, bf);
    assign first = (stage == '0) && (bf == '0);

    // Reads of the current butterfly interleave with the tail writes of the previous one
    always_comb begin
        agu = '0;
        unique case (state)
            S_RUN: begin
                case (cnt)
                    SLOT_B_RE: begin
                        agu.rd_addr = {b, 1'b0};
                        if (!first) begin
                            agu.wr_en   = 1'b1;
                            agu.wr_addr = {prev_b, 1'b0};
                        end
                    end
                    SLOT_W_RE: begin
                        agu.tw_addr = {k, 1'b0};
                        agu.tw_sel  = 1'b1;
                        if (!first) begin
                            agu.wr_en   = 1'b1;
                            agu.wr_addr = {prev_b, 1'b1};
                        end
                    end
                    SLOT_B_IM: agu.rd_addr = {b, 1'b1};
                    SLOT_W_IM: begin
                        agu.tw_addr = {k, 1'b1};
                        agu.tw_sel  = 1'b1;
                    end
                    SLOT_A_RE: agu.rd_addr = {a, 1'b0};
                    SLOT_A_IM: agu.rd_addr = {a, 1'b1};
                    SLOT_WR_A_RE: begin
                        agu.wr_en   = 1'b1;
                        agu.wr_addr = {a, 1'b0};
                    end
                    SLOT_WR_A_IM: begin
                        agu.wr_en   = 1'b1;
                        agu.wr_addr = {a, 1'b1};
                    end
                    default: ;
                endcase
            end
            S_DRAIN: begin
                agu.wr_en   = 1'b1;
                agu.wr_addr = {prev_b, cnt[0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/butterfly_sequencer.sv
// Sequences LOG2N stages x N/2 butterflies of an in-place DIT FFT; all outputs registered from next-state values.
// Optional BFSEQ_ROWBASE_EN adds xRowBase, latched on accepted xGo, as the upper data-address bits.
module butterfly_sequencer
    import butterfly_sequencer_pkg::*;
(
    input  logic              xClock,
    input  logic              xReset_n,
    input  logic              xGo,
`ifdef BFSEQ_ROWBASE_EN
    input  logic [ROW_AW-1:0] xRowBase,
`endif
    output logic              xBusy,
    output logic              xDone,
    output logic              bf_start,
    output logic              bf_reset,
    output logic              bf_tri,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [TW_AW-1:0]  tw_addr,
    output logic              tw_sel
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BF_W-1:0]    bf, bf_nxt;
    logic [STAGE_W-1:0] stage, stage_nxt;
    logic [LOG2N-1:0]   prev_b, prev_b_nxt;
    logic [ADDR_W-1:0]  rd_addr_nxt;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    agu_out_t           agu_nxt;
`ifdef BFSEQ_ROWBASE_EN
    logic [ROW_AW-1:0]  row, row_nxt;
`endif

    // Next-state and counter logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bf_nxt     = bf;
        stage_nxt  = stage;
        prev_b_nxt = prev_b;
`ifdef BFSEQ_ROWBASE_EN
        row_nxt    = row;
`endif
        unique case (state)
            S_IDLE: begin
                if (xGo) begin
                    state_nxt  = S_RUN;
                    cnt_nxt    = '0;
                    bf_nxt     = '0;
                    stage_nxt  = '0;
                    prev_b_nxt = '0;
`ifdef BFSEQ_ROWBASE_EN
                    row_nxt    = xRowBase;
`endif
                end
            end
            S_RUN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == SLOT_WR_A_IM) begin
                    prev_b_nxt = bfly_b(stage, bf);
                    bf_nxt     = bf + BF_W'(1);
                    if (bf == BF_LAST) begin
                        bf_nxt    = '0;
                        stage_nxt = stage + STAGE_W'(1);
                        if (stage == STAGE_LAST) begin
                            stage_nxt = '0;
                            state_nxt = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_CLR;
                end
            end
            S_CLR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    butterfly_sequencer_agu u_agu (
        .state  (state_nxt),
        .stage  (stage_nxt),
        .bf     (bf_nxt),
        .cnt    (cnt_nxt),
        .prev_b (prev_b_nxt),
        .agu    (agu_nxt)
    );

`ifdef BFSEQ_ROWBASE_EN
    assign rd_addr_nxt = {row_nxt, agu_nxt.rd_addr};
    assign wr_addr_nxt = {row_nxt, agu_nxt.wr_addr};
`else
    assign rd_addr_nxt = agu_nxt.rd_addr;
    assign wr_addr_nxt = agu_nxt.wr_addr;
`endif

    always_ff @(posedge xClock or negedge xReset_n) begin
        if (!xReset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bf       <= '0;
            stage    <= '0;
            prev_b   <= '0;
`ifdef BFSEQ_ROWBASE_EN
            row      <= '0;
`endif
            xBusy    <= 1'b0;
            xDone    <= 1'b0;
            bf_start <= 1'b0;
            bf_reset <= 1'b1;
            bf_tri   <= 1'b1;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_en    <= 1'b0;
            tw_addr  <= '0;
            tw_sel   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bf       <= bf_nxt;
            stage    <= stage_nxt;
            prev_b   <= prev_b_nxt;
`ifdef BFSEQ_ROWBASE_EN
            row      <= row_nxt;
`endif
            xBusy    <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            xDone    <= (state_nxt == S_CLR);
            bf_start <= (state == S_IDLE) && (state_nxt == S_RUN);
            bf_reset <= (state_nxt == S_IDLE) || (state_nxt == S_CLR);
            bf_tri   <= !agu_nxt.wr_en;
            rd_addr  <= rd_addr_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_en    <= agu_nxt.wr_en;
            tw_addr  <= agu_nxt.tw_addr;
            tw_sel   <= agu_nxt.tw_sel;
        end
    end

endmodule

// File: tb/tb_butterfly_sequencer.sv
// Self-checking bench for butterfly_sequencer: per-cycle schedule model, spot-check table, and corner-case sequences.
module tb_butterfly_sequencer;

    localparam int N        = 16;
    localparam int LOG2N    = 4;
    localparam int NB       = N / 2;
    localparam int RUN_CYC  = LOG2N * NB * 8;
    localparam int DONE_CYC = RUN_CYC + 3;
    localparam int LAST     = DONE_CYC + 1;

    localparam int F_RD = 0, F_TW = 1, F_SEL = 2, F_WE = 3, F_WR = 4, F_START = 5, F_DONE = 6;

    typedef struct {
        int cyc;
        int fld;
        int exp;
    } vec_t;

    logic       xClock = 1'b0;
    logic       xReset_n;
    logic       xGo;
    logic       xBusy, xDone, bf_start, bf_reset, bf_tri, wr_en, tw_sel;
    logic [4:0] rd_addr, wr_addr;
    logic [3:0] tw_addr;

    int checks   = 0;
    int failures = 0;

    int m_rd [0:LAST];
    int m_wr [0:LAST];
    int m_tw [0:LAST];
    int m_sel[0:LAST];
    int m_we [0:LAST];

    int t_rd [0:LAST];
    int t_wr [0:LAST];
    int t_tw [0:LAST];
    int t_sel[0:LAST];
    int t_we [0:LAST];
    int t_st [0:LAST];
    int t_dn [0:LAST];

    vec_t tbl[$];

    butterfly_sequencer dut (
        .xClock   (xClock),
        .xReset_n (xReset_n),
        .xGo      (xGo),
        .xBusy    (xBusy),
        .xDone    (xDone),
        .bf_start (bf_start),
        .bf_reset (bf_reset),
        .bf_tri   (bf_tri),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .wr_en    (wr_en),
        .tw_addr  (tw_addr),
        .tw_sel   (tw_sel)
    );

    always #5 xClock = ~xClock;

    // Expected per-cycle schedule of one run, placed butterfly by butterfly from the address formulas
    task automatic build_model();
        for (int c = 0; c <= LAST; c++) begin
            m_rd[c] = 0; m_wr[c] = 0; m_tw[c] = 0; m_sel[c] = 0; m_we[c] = 0;
        end
        for (int s = 0; s < LOG2N; s++) begin
            for (int bf = 0; bf < NB; bf++) begin
                int half, a, b, k, c0;
                half = 1 << s;
                a    = (bf / half) * 2 * half + (bf % half);
                b    = a + half;
                k    = (bf % half) * (NB / half);
                c0   = 1 + 8 * (s * NB + bf);
                m_rd[c0]     = 2 * b;
                m_tw[c0 + 1] = 2 * k;     m_sel[c0 + 1] = 1;
                m_rd[c0 + 2] = 2 * b + 1;
                m_tw[c0 + 3] = 2 * k + 1; m_sel[c0 + 3] = 1;
                m_rd[c0 + 4] = 2 * a;
                m_rd[c0 + 5] = 2 * a + 1;
                m_wr[c0 + 6] = 2 * a;     m_we[c0 + 6] = 1;
                m_wr[c0 + 7] = 2 * a + 1; m_we[c0 + 7] = 1;
                m_wr[c0 + 8] = 2 * b;     m_we[c0 + 8] = 1;
                m_wr[c0 + 9] = 2 * b + 1; m_we[c0 + 9] = 1;
            end
        end
    endtask

    function automatic logic [20:0] pack_exp(input int c);
        logic busy, done, st, rst, we;
        busy = (c >= 1) && (c < DONE_CYC);
        done = (c == DONE_CYC);
        st   = (c == 1);
        rst  = (c == 0) || (c >= DONE_CYC);
        we   = 1'(m_we[c]);
        return {busy, done, st, rst, ~we, we, 1'(m_sel[c]), 5'(m_rd[c]), 5'(m_wr[c]), 4'(m_tw[c])};
    endfunction

    function automatic logic [20:0] pack_act();
        return {xBusy, xDone, bf_start, bf_reset, bf_tri, wr_en, tw_sel, rd_addr, wr_addr, tw_addr};
    endfunction

    function automatic int trace_get(input int fld, input int c);
        case (fld)
            F_RD:    return t_rd[c];
            F_TW:    return t_tw[c];
            F_SEL:   return t_sel[c];
            F_WE:    return t_we[c];
            F_WR:    return t_wr[c];
            F_START: return t_st[c];
            default: return t_dn[c];
        endcase
    endfunction

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge xClock);
        #1;
    endtask

    // One full run from an xGo pulse, compared cycle by cycle; optional random xGo noise while busy
    task automatic do_run(input bit noise, input bit record);
        xGo = 1'b1;
        tick();
        xGo = 1'b0;
        for (int c = 1; c <= DONE_CYC; c++) begin
            check("run_cycle", c, 32'(pack_act()), 32'(pack_exp(c)));
            if (record) begin
                t_rd[c] = int'(rd_addr); t_wr[c] = int'(wr_addr); t_tw[c] = int'(tw_addr);
                t_sel[c] = int'(tw_sel); t_we[c] = int'(wr_en);
                t_st[c] = int'(bf_start); t_dn[c] = int'(xDone);
            end
            if (noise && c < DONE_CYC) xGo = 1'($urandom_range(0, 1));
            else                       xGo = 1'b0;
            tick();
        end
        check("post_run_idle", LAST, 32'(pack_act()), 32'(pack_exp(0)));
    endtask

    initial begin
        int dcnt, dfirst;
        xReset_n = 1'b0;
        xGo      = 1'b0;
        build_model();

        tbl.push_back('{1, F_START, 1});   tbl.push_back('{2, F_START, 0});
        tbl.push_back('{1, F_RD, 2});      tbl.push_back('{2, F_TW, 0});
        tbl.push_back('{2, F_SEL, 1});     tbl.push_back('{3, F_RD, 3});
        tbl.push_back('{4, F_TW, 1});      tbl.push_back('{5, F_RD, 0});
        tbl.push_back('{6, F_RD, 1});      tbl.push_back('{1, F_WE, 0});
        tbl.push_back('{2, F_WE, 0});      tbl.push_back('{7, F_WE, 1});
        tbl.push_back('{7, F_WR, 0});      tbl.push_back('{8, F_WR, 1});
        tbl.push_back('{169, F_RD, 26});   tbl.push_back('{170, F_TW, 4});
        tbl.push_back('{171, F_RD, 27});   tbl.push_back('{172, F_TW, 5});
        tbl.push_back('{173, F_RD, 18});   tbl.push_back('{174, F_RD, 19});
        tbl.push_back('{175, F_WR, 18});   tbl.push_back('{176, F_WR, 19});
        tbl.push_back('{177, F_WR, 26});   tbl.push_back('{178, F_WR, 27});
        tbl.push_back('{177, F_WE, 1});    tbl.push_back('{257, F_WR, 30});
        tbl.push_back('{258, F_WR, 31});   tbl.push_back('{258, F_WE, 1});
        tbl.push_back('{258, F_DONE, 0});  tbl.push_back('{259, F_DONE, 1});

        repeat (2) tick();
        check("reset_state", 0, 32'(pack_act()), 32'(pack_exp(0)));
        #2 xReset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_no_go", i, 32'(pack_act()), 32'(pack_exp(0)));
        end

        do_run(1'b0, 1'b1);
        foreach (tbl[i])
            check("table", tbl[i].cyc, 32'(trace_get(tbl[i].fld, tbl[i].cyc)), 32'(tbl[i].exp));

        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(1, 5)) tick();
            do_run(1'b1, 1'b0);
        end

        // xGo held high through most of a run: exactly one xDone, at the fixed latency
        tick();
        dcnt = 0; dfirst = 0;
        xGo = 1'b1;
        tick();
        for (int c = 1; c <= 300; c++) begin
            if (xDone) begin
                dcnt++;
                if (dfirst == 0) dfirst = c;
            end
            if (c == 200) xGo = 1'b0;
            tick();
        end
        check("held_go_done_count", 0, 32'(dcnt), 32'd1);
        check("held_go_done_cycle", 0, 32'(dfirst), 32'(DONE_CYC));

        // Asynchronous reset mid-run aborts straight to idle
        xGo = 1'b1;
        tick();
        xGo = 1'b0;
        repeat (99) tick();
        check("busy_at_100", 100, 32'(xBusy), 32'd1);
        #2 xReset_n = 1'b0;
        #1 check("async_reset_now", 100, 32'(pack_act()), 32'(pack_exp(0)));
        tick();
        check("async_reset_edge", 101, 32'(pack_act()), 32'(pack_exp(0)));
        #2 xReset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_after_abort", i, 32'(pack_act()), 32'(pack_exp(0)));
        end
        do_run(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
